// File: rtl/pi_alu_pkg.sv
// rtl/pi_alu_pkg.sv - shared opcodes, register addresses and bit indices for pi_alu
package pi_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MULU = 3'd5,
    OP_MULS = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  localparam logic [4:0] ADDR_A0     = 5'h00;
  localparam logic [4:0] ADDR_B0     = 5'h04;
  localparam logic [4:0] ADDR_R0     = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h11;

  localparam int CTRL_IRQ_EN = 6;
  localparam int CTRL_START  = 7;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_CARRY = 2;
  localparam int STAT_ERR   = 3;

  function automatic logic op_is_mul(input op_e op);
    return (op == OP_MULU) || (op == OP_MULS);
  endfunction

endpackage

// File: rtl/pi_alu_mul.sv
// rtl/pi_alu_mul.sv - sequential 32x32 unsigned shift-add multiplier (built only with ALU_MUL_EN)
//   clk, rst (async, active-low), start: load a/b and begin 32 iterations
//   busy: iterating; done: high in the cycle whose closing edge completes the product
//   product: 64-bit unsigned result, final from the edge after done
`ifdef ALU_MUL_EN
module pi_alu_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic [32:0] sum;

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    // Upper half accumulates; lower half holds the unconsumed multiplier bits.
    sum     = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    if (start && !busy_q) begin
      busy_d  = 1'b1;
      cnt_d   = 5'd0;
      mcand_d = a;
      prod_d  = {32'd0, b};
    end else if (busy_q) begin
      prod_d = {sum, prod_q[31:1]};
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'd31) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= 5'd0;
      mcand_q <= 32'd0;
      prod_q  <= 64'd0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == 5'd31);
  assign product = prod_q;

endmodule
`endif

// File: rtl/pi_alu.sv
// rtl/pi_alu.sv - memory-mapped 32-bit ALU co-processor on the PicoBlaze pi bus
//   pi_blk_sel/pi_addr/pi_wr_en/pi_rd_en/pi_wr_data: byte register access
//   pi_rd_data: registered read byte, zero when not read
//   interrupt/interrupt_ack: completion interrupt, level, set wins over ack
//   ALU_MUL_EN: enables opcodes MULU/MULS and the sequential multiplier
module pi_alu
  import pi_alu_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 5,
  parameter int OPW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pi_blk_sel,
  input  logic [AW-1:0] pi_addr,
  input  logic          pi_wr_en,
  input  logic          pi_rd_en,
  input  logic [DW-1:0] pi_wr_data,
  output logic [DW-1:0] pi_rd_data,
  input  logic          interrupt_ack,
  output logic          interrupt
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d;
  logic [2*OPW-1:0] r_q, r_d;
  logic [2:0]      opcode_q, opcode_d;
  logic            irq_en_q, irq_en_d;
  op_e             run_op_q, run_op_d;
  logic            done_q, done_d, carry_q, carry_d, err_q, err_d;
  logic            irq_q, irq_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            wr_hit, rd_hit, busy, mul_free, start_is_mul;
  logic [OPW:0]    sum_ext, dif_ext;
  logic [DW-1:0]   ctrl_rd, status_rd;
  op_e             start_op;

`ifdef ALU_MUL_EN
  logic            neg_q, neg_d;
  logic            mul_start, mul_busy, mul_done;
  logic [31:0]     mul_a, mul_b;
  logic [63:0]     mul_product;

  // MULS multiplies magnitudes; the sign is reapplied when R is latched.
  assign mul_a = (start_op == OP_MULS && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign mul_b = (start_op == OP_MULS && b_q[31]) ? (~b_q + 32'd1) : b_q;
  assign mul_free = !mul_busy;
  assign start_is_mul = op_is_mul(start_op);

  pi_alu_mul u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_free = 1'b1;
  assign start_is_mul = 1'b0;
`endif

  assign start_op = op_e'(pi_wr_data[2:0]);
  assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
  assign dif_ext  = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    opcode_d  = opcode_q;
    irq_en_d  = irq_en_q;
    run_op_d  = run_op_q;
    done_d    = done_q;
    carry_d   = carry_q;
    err_d     = err_q;
    irq_d     = irq_q;
    rd_data_d = '0;
`ifdef ALU_MUL_EN
    neg_d     = neg_q;
    mul_start = 1'b0;
`endif
    wr_hit    = pi_blk_sel & pi_wr_en;
    rd_hit    = pi_blk_sel & pi_rd_en;
    busy      = (state_q == ST_MUL);

    ctrl_rd              = '0;
    ctrl_rd[2:0]         = opcode_q;
    ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
    status_rd             = '0;
    status_rd[STAT_BUSY]  = busy;
    status_rd[STAT_DONE]  = done_q;
    status_rd[STAT_CARRY] = carry_q;
    status_rd[STAT_ERR]   = err_q;

    if (rd_hit) begin
      if (pi_addr[4:2] == ADDR_A0[4:2])      rd_data_d = a_q[{pi_addr[1:0], 3'b000} +: 8];
      else if (pi_addr[4:2] == ADDR_B0[4:2]) rd_data_d = b_q[{pi_addr[1:0], 3'b000} +: 8];
      else if (pi_addr[4:3] == ADDR_R0[4:3]) rd_data_d = r_q[{pi_addr[2:0], 3'b000} +: 8];
      else if (pi_addr == ADDR_CTRL)         rd_data_d = ctrl_rd;
      else if (pi_addr == ADDR_STATUS)       rd_data_d = status_rd;
    end

    if (interrupt_ack) irq_d = 1'b0;

    // Operand and control writes are frozen only while the multiplier runs.
    if (wr_hit && !busy) begin
      if (pi_addr[4:2] == ADDR_A0[4:2]) a_d[{pi_addr[1:0], 3'b000} +: 8] = pi_wr_data;
      if (pi_addr[4:2] == ADDR_B0[4:2]) b_d[{pi_addr[1:0], 3'b000} +: 8] = pi_wr_data;
      if (pi_addr == ADDR_CTRL) begin
        opcode_d = pi_wr_data[2:0];
        irq_en_d = pi_wr_data[CTRL_IRQ_EN];
        if (pi_wr_data[CTRL_START] && state_q == ST_IDLE && mul_free) begin
          done_d   = 1'b0;
          carry_d  = 1'b0;
          err_d    = 1'b0;
          run_op_d = start_op;
          if (start_is_mul) begin
            state_d = ST_MUL;
`ifdef ALU_MUL_EN
            mul_start = 1'b1;
            neg_d     = (start_op == OP_MULS) && (a_q[31] ^ b_q[31]);
`endif
          end else begin
            state_d = ST_DONE;
          end
        end
      end
    end

    case (state_q)
      ST_MUL: begin
`ifdef ALU_MUL_EN
        if (mul_done) state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (irq_en_q) irq_d = 1'b1;
        r_d     = '0;
        case (run_op_q)
          OP_ADD: begin
            r_d[OPW-1:0] = sum_ext[OPW-1:0];
            carry_d      = sum_ext[OPW];
          end
          OP_SUB: begin
            r_d[OPW-1:0] = dif_ext[OPW-1:0];
            carry_d      = dif_ext[OPW];
          end
          OP_AND: r_d[OPW-1:0] = a_q & b_q;
          OP_OR:  r_d[OPW-1:0] = a_q | b_q;
          OP_XOR: r_d[OPW-1:0] = a_q ^ b_q;
`ifdef ALU_MUL_EN
          OP_MULU: r_d = mul_product;
          OP_MULS: r_d = neg_q ? (~mul_product + 64'd1) : mul_product;
`endif
          default: err_d = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      opcode_q  <= '0;
      irq_en_q  <= 1'b0;
      run_op_q  <= OP_ADD;
      done_q    <= 1'b0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
`ifdef ALU_MUL_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      opcode_q  <= opcode_d;
      irq_en_q  <= irq_en_d;
      run_op_q  <= run_op_d;
      done_q    <= done_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
`ifdef ALU_MUL_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign pi_rd_data = rd_data_q;
  assign interrupt  = irq_q;

endmodule

// File: tb/tb_pi_alu.sv
// tb/tb_pi_alu.sv - scoreboard bench for pi_alu (expectations follow ALU_MUL_EN)
module tb_pi_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       pi_blk_sel;
  logic [4:0] pi_addr;
  logic       pi_wr_en;
  logic       pi_rd_en;
  logic [7:0] pi_wr_data;
  logic [7:0] pi_rd_data;
  logic       interrupt_ack;
  logic       interrupt;

  logic       probe = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         s;
  logic [8:0] exp_q[$];
  string      name_q[$];

  pi_alu dut (
    .clk           (clk),
    .rst           (rst),
    .pi_blk_sel    (pi_blk_sel),
    .pi_addr       (pi_addr),
    .pi_wr_en      (pi_wr_en),
    .pi_rd_en      (pi_rd_en),
    .pi_wr_data    (pi_wr_data),
    .pi_rd_data    (pi_rd_data),
    .interrupt_ack (interrupt_ack),
    .interrupt     (interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: a read strobe or irq probe across an edge yields one response after it.
  initial begin
    logic       fire;
    logic [8:0] e;
    string      n;
    forever begin
      @(posedge clk);
      fire = pi_rd_en | probe;
      @(negedge clk);
      if (fire) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_underflow: response seen with nothing expected");
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (e[8]) begin
            if (interrupt !== e[0]) begin
              fails++;
              $display("FAIL %s: interrupt got %b expected %b", n, interrupt, e[0]);
            end
          end else if (pi_rd_data !== e[7:0]) begin
            fails++;
            $display("FAIL %s: rd_data got 0x%02h expected 0x%02h", n, pi_rd_data, e[7:0]);
          end
        end
      end
    end
  end

  // All tasks start and end at posedge+#1.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t - 1) idle(1);
  endtask

  task automatic wr_sel(input logic sel, input logic [4:0] addr, input logic [7:0] data);
    pi_blk_sel = sel; pi_addr = addr; pi_wr_data = data; pi_wr_en = 1'b1;
    @(posedge clk); #1;
    pi_wr_en = 1'b0; pi_blk_sel = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [7:0] data);
    wr_sel(1'b1, addr, data);
  endtask

  task automatic wr32(input logic [4:0] base, input logic [31:0] v);
    for (int i = 0; i < 4; i++) wr(base + 5'(i), v[8*i +: 8]);
  endtask

  task automatic rd_sel(input logic sel, input logic [4:0] addr, input logic [7:0] expv, input string n);
    exp_q.push_back({1'b0, expv});
    name_q.push_back(n);
    pi_blk_sel = sel; pi_addr = addr; pi_rd_en = 1'b1;
    @(posedge clk); #1;
    pi_rd_en = 1'b0; pi_blk_sel = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [7:0] expv, input string n);
    rd_sel(1'b1, addr, expv, n);
  endtask

  task automatic chk_r64(input logic [63:0] v, input string tag);
    for (int i = 0; i < 8; i++) rd(5'h08 + 5'(i), v[8*i +: 8], $sformatf("%s_r%0d", tag, i));
  endtask

  task automatic chk_irq(input logic expv, input string n);
    exp_q.push_back({1'b1, 7'd0, expv});
    name_q.push_back(n);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    @(posedge clk); #1;
    interrupt_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pi_blk_sel = 1'b0; pi_addr = '0; pi_wr_en = 1'b0;
    pi_rd_en = 1'b0; pi_wr_data = '0; interrupt_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Reset state
    for (int i = 0; i < 18; i++) rd(5'(i), 8'h00, $sformatf("reset_byte_%02h", i));
    chk_irq(1'b0, "reset_irq");

    // ADD with carry out and interrupt
    wr32(5'h00, 32'hFFFF_FFFF);
    wr32(5'h04, 32'h0000_0001);
    wr(5'h10, 8'hC0);
    idle(2);
    rd(5'h11, 8'h06, "add_status");
    rd(5'h10, 8'h40, "add_ctrl");
    chk_r64(64'h0, "add");
    chk_irq(1'b1, "add_irq");
    ack();
    chk_irq(1'b0, "add_irq_acked");
    rd(5'h11, 8'h06, "add_done_kept");

    // SUB with borrow, no interrupt
    wr32(5'h00, 32'h0000_0005);
    wr32(5'h04, 32'h0000_0007);
    wr(5'h10, 8'h81);
    idle(2);
    rd(5'h11, 8'h06, "sub_status");
    chk_r64(64'h0000_0000_FFFF_FFFE, "sub");
    chk_irq(1'b0, "sub_irq");

    // MULS -3 * 5
    wr32(5'h00, 32'hFFFF_FFFD);
    wr32(5'h04, 32'h0000_0005);
    wr(5'h10, 8'hC6);
    s = cyc;
`ifdef ALU_MUL_EN
    wr(5'h10, 8'h80);
    wr(5'h00, 8'h12);
    rd(5'h11, 8'h01, "muls_busy_early");
    wait_to(s + 32);
    rd(5'h11, 8'h01, "muls_busy_last");
    rd(5'h11, 8'h00, "muls_done_state");
    rd(5'h11, 8'h02, "muls_done");
    chk_r64(64'hFFFF_FFFF_FFFF_FFF1, "muls");
    rd(5'h00, 8'hFD, "muls_a_write_ignored");
    rd(5'h10, 8'h46, "muls_ctrl_write_ignored");
`else
    idle(2);
    rd(5'h11, 8'h0A, "muls_illegal_status");
    chk_r64(64'h0, "muls_illegal");
`endif
    chk_irq(1'b1, "muls_irq");
    ack();
    chk_irq(1'b0, "muls_irq_acked");

    // MULU max operands
    wr32(5'h00, 32'hFFFF_FFFF);
    wr32(5'h04, 32'hFFFF_FFFF);
    wr(5'h10, 8'h85);
    s = cyc;
`ifdef ALU_MUL_EN
    wait_to(s + 36);
    rd(5'h11, 8'h02, "mulu_status");
    chk_r64(64'hFFFF_FFFE_0000_0001, "mulu");
`else
    idle(2);
    rd(5'h11, 8'h0A, "mulu_illegal_status");
    chk_r64(64'h0, "mulu_illegal");
`endif
    chk_irq(1'b0, "mulu_irq");

    // Illegal opcode
    wr(5'h10, 8'h87);
    idle(2);
    rd(5'h11, 8'h0A, "ill_status");
    rd(5'h10, 8'h07, "ill_ctrl");
    chk_r64(64'h0, "ill");

    // Bus qualification
    rd_sel(1'b0, 5'h00, 8'h00, "unselected_read");
    wr_sel(1'b0, 5'h00, 8'h33);
    rd(5'h00, 8'hFF, "unselected_write_ignored");
    wr(5'h15, 8'h5A);
    rd(5'h15, 8'h00, "reserved_read");

    // Reset in the middle of a multiply
    wr32(5'h00, 32'h0000_1234);
    wr32(5'h04, 32'h0000_0003);
    wr(5'h10, 8'hC5);
    idle(5);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(40);
    chk_irq(1'b0, "midreset_irq");
    rd(5'h11, 8'h00, "midreset_status");
    rd(5'h00, 8'h00, "midreset_a");
    rd(5'h10, 8'h00, "midreset_ctrl");
    chk_r64(64'h0, "midreset");

    idle(3);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d responses missing, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
